// File: rtl/ram_fill_arbiter.sv
// Shares the CPU-side RAM port between the CPU and a constant-value fill engine.
// Define FILL_STARVE_GUARD_EN to force a fill slot after MAX_WAIT consecutive denials.
module ram_fill_arbiter #(
  parameter int WIDTH          = 16,
  parameter int REGISTER_COUNT = 4096,
  parameter int MAX_WAIT       = 15,
  parameter int AW             = $clog2(REGISTER_COUNT)
) (
  input  logic             cpu_clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             cpu_we,
  output logic             cpu_gnt,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             fill_start,
  input  logic [AW-1:0]    fill_base,
  input  logic [AW:0]      fill_len,
  input  logic [WIDTH-1:0] fill_value,
  output logic             fill_busy,
  output logic             fill_done,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_ptr;
  logic [AW:0]      r_rem;
  logic [WIDTH-1:0] r_val;
  logic             r_busy;
  logic             r_done;
  logic             w_force;
  logic             w_fill_gnt;

`ifdef FILL_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] r_wait_cnt;

  assign w_force = (r_wait_cnt == WW'(MAX_WAIT));

  always_ff @(posedge cpu_clk) begin
    if (rst || r_state != FILL || w_fill_gnt) r_wait_cnt <= '0;
    else                                      r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`else
  // CPU always wins; the comparison is constant false
  assign w_force = (MAX_WAIT < 0);
`endif

  assign w_fill_gnt = (r_state == FILL) && !rst && (!cpu_req || w_force);

  always_comb begin
    cpu_gnt   = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    if (w_fill_gnt) begin
      ram_addr  = r_ptr;
      ram_wdata = r_val;
      ram_we    = 1'b1;
    end else if (!rst) begin
      cpu_gnt = cpu_req;
      ram_we  = cpu_req & cpu_we;
    end
  end

  assign cpu_rdata = ram_rdata;
  assign fill_busy = r_busy;
  assign fill_done = r_done;

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_val   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (fill_start) begin
            r_ptr <= fill_base;
            r_rem <= fill_len;
            r_val <= fill_value;
            if (fill_len != '0) begin
              r_state <= FILL;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (w_fill_gnt) begin
            // explicit wrap so non-power-of-2 depths never address past the end
            r_ptr <= (r_ptr == AW'(REGISTER_COUNT - 1)) ? '0 : r_ptr + 1'b1;
            r_rem <= r_rem - 1'b1;
            if (r_rem == (AW+1)'(1)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fill_arbiter.sv
// Directed bench for ram_fill_arbiter with a behavioural async-read RAM attached.
module tb_ram_fill_arbiter;
  localparam int W  = 16;
  localparam int RC = 4096;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt;
  logic [AW-1:0] cpu_addr, fill_base, ram_addr;
  logic [W-1:0]  cpu_wdata, cpu_rdata, fill_value, ram_wdata, ram_rdata;
  logic [AW:0]   fill_len;
  logic          fill_start, fill_busy, fill_done, ram_we;

  logic [W-1:0] mem [RC];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_fill_arbiter #(.WIDTH(W), .REGISTER_COUNT(RC), .MAX_WAIT(3)) dut (
    .cpu_clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [AW:0] l, input logic [W-1:0] v);
    fill_start = 1'b1; fill_base = b; fill_len = l; fill_value = v;
    tick();
    fill_start = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ea [4];
    int wr, gn, dn;

    for (int i = 0; i < RC; i++) mem[i] = '0;
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 16'hDEAD;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
    tick(); tick();
    smp();
    chk("rst_we",   32'(ram_we),    0);
    chk("rst_gnt",  32'(cpu_gnt),   0);
    chk("rst_busy", 32'(fill_busy), 0);
    chk("rst_done", 32'(fill_done), 0);
    tick(); rst = 1'b0;

    // idle passthrough write then read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 16'h1234;
    smp();
    chk("pt_wr_gnt",  32'(cpu_gnt),  1);
    chk("pt_wr_we",   32'(ram_we),   1);
    chk("pt_wr_addr", 32'(ram_addr), 32'h010);
    tick(); cpu_we = 1'b0;
    smp();
    chk("pt_rd_gnt",   32'(cpu_gnt),   1);
    chk("pt_rd_we",    32'(ram_we),    0);
    chk("pt_rd_rdata", 32'(cpu_rdata), 32'h1234);
    tick(); cpu_req = 1'b0; cpu_addr = 12'h055;
    smp();
    chk("idle_we",   32'(ram_we),   0);
    chk("idle_addr", 32'(ram_addr), 32'h055);
    tick();

    // uncontended fill of 4 words
    start(12'h100, 13'd4, 16'hABCD);
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("uf_we",   32'(ram_we),    1);
      chk("uf_addr", 32'(ram_addr),  32'h100 + 32'(i));
      chk("uf_data", 32'(ram_wdata), 32'hABCD);
      chk("uf_busy", 32'(fill_busy), 1);
      chk("uf_done", 32'(fill_done), 0);
      tick();
    end
    smp();
    chk("uf_done_pulse", 32'(fill_done), 1);
    chk("uf_busy_off",   32'(fill_busy), 0);
    chk("uf_we_off",     32'(ram_we),    0);
    tick(); smp();
    chk("uf_done_1cyc", 32'(fill_done), 0);
    chk("uf_mem",       32'(mem[12'h103]), 32'hABCD);
    tick();

    // zero length
    start(12'h300, 13'd0, 16'h9999);
    smp();
    chk("z_done", 32'(fill_done), 1);
    chk("z_we",   32'(ram_we),    0);
    chk("z_busy", 32'(fill_busy), 0);
    tick(); smp();
    chk("z_done_1cyc", 32'(fill_done), 0);
    tick();

    // wrap at top of RAM
    ea[0] = 12'hFFE; ea[1] = 12'hFFF; ea[2] = 12'h000; ea[3] = 12'h001;
    start(12'hFFE, 13'd4, 16'h0F0F);
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("wr_we",   32'(ram_we),   1);
      chk("wr_addr", 32'(ram_addr), 32'(ea[i]));
      tick();
    end
    smp();
    chk("wr_done", 32'(fill_done), 1);
    tick();

    // contention: CPU holds request for 20 cycles
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    start(12'h200, 13'd2, 16'h5555);
`ifdef FILL_STARVE_GUARD_EN
    for (int k = 1; k <= 8; k++) begin
      smp();
      chk("sg_gnt", 32'(cpu_gnt), (k % 4 == 0) ? 0 : 1);
      chk("sg_we",  32'(ram_we),  (k % 4 == 0) ? 1 : 0);
      tick();
    end
    smp();
    chk("sg_done", 32'(fill_done), 1);
    cpu_req = 1'b0;
    tick();
`else
    wr = 0; gn = 0;
    for (int k = 0; k < 20; k++) begin
      smp();
      gn += int'(cpu_gnt);
      wr += int'(ram_we);
      tick();
    end
    chk("ct_gnt_cnt", 32'(gn), 20);
    chk("ct_wr_cnt",  32'(wr), 0);
    chk("ct_busy",    32'(fill_busy), 1);
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("ct_rel_we",   32'(ram_we),   1);
      chk("ct_rel_addr", 32'(ram_addr), 32'h200 + 32'(i));
      tick();
    end
    smp();
    chk("ct_done", 32'(fill_done), 1);
    tick();
`endif

    // reset after 2 of 8 words
    start(12'h300, 13'd8, 16'h7777);
    tick(); tick();
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h3F0;
    smp();
    chk("rm_we",  32'(ram_we),  0);
    chk("rm_gnt", 32'(cpu_gnt), 0);
    tick(); rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      dn += int'(fill_done);
      chk("rm_busy", 32'(fill_busy), 0);
      tick();
    end
    chk("rm_no_done", 32'(dn), 0);
    chk("rm_kept",    32'(mem[12'h301]), 32'h7777);
    chk("rm_unwr",    32'(mem[12'h302]), 0);

    // start pulse mid-fill is ignored
    start(12'h400, 13'd3, 16'h1111);
    fill_start = 1'b1; fill_base = 12'h500; fill_len = 13'd1; fill_value = 16'h2222;
    smp();
    chk("ig_addr0", 32'(ram_addr), 32'h400);
    tick(); fill_start = 1'b0;
    for (int i = 1; i < 3; i++) begin
      smp();
      chk("ig_addr", 32'(ram_addr),  32'h400 + 32'(i));
      chk("ig_data", 32'(ram_wdata), 32'h1111);
      tick();
    end
    smp();
    chk("ig_done", 32'(fill_done), 1);
    chk("ig_mem",  32'(mem[12'h500]), 0);
    tick();

    // full-depth fill starting mid-RAM
    start(12'h800, 13'd4096, 16'hC3C3);
    wr = 0; dn = 0;
    for (int k = 0; k < 4200 && dn == 0; k++) begin
      smp();
      wr += int'(ram_we);
      dn = int'(fill_done);
      tick();
    end
    chk("full_done",  32'(dn), 1);
    chk("full_count", 32'(wr), 4096);
    chk("full_lo",    32'(mem[12'h000]), 32'hC3C3);
    chk("full_7ff",   32'(mem[12'h7FF]), 32'hC3C3);
    chk("full_ptr",   32'(dut.r_ptr),    32'h800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
